// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared constants and types for the writeback arbiter
package rf_wb_arbiter_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_GPR    = 32;

  typedef logic [ADDR_W_DEF-1:0] regaddr_t;

  localparam regaddr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback request, decode lookup and register-file write bundle
interface rf_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;

  logic                      issue_valid;
  logic [ADDR_W-1:0]         issue_addr;
  logic [ADDR_W-1:0]         rs_addr;
  logic [ADDR_W-1:0]         rt_addr;
  logic                      rs_busy;
  logic                      rt_busy;

  logic                      rf_w;
  logic [ADDR_W-1:0]         rf_addr;
  logic [DATA_W-1:0]         rf_data;

  modport slave (
    input  req_valid, req_addr, req_data,
    input  issue_valid, issue_addr, rs_addr, rt_addr,
    output req_ready, rs_busy, rt_busy,
    output rf_w, rf_addr, rf_data
  );

  modport master (
    output req_valid, req_addr, req_data,
    output issue_valid, issue_addr, rs_addr, rt_addr,
    input  req_ready, rs_busy, rt_busy,
    input  rf_w, rf_addr, rf_data
  );

endinterface

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// rtl/rf_wb_arbiter_rr_arbiter.sv - round-robin one-hot arbiter with internal priority pointer
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               grant_any_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_idx;
  logic          found;
  int            j;

  // Scan starts at ptr_q and wraps; ptr_q < NUM_REQ so one subtraction suffices.
  always_comb begin
    grant_o = '0;
    win_idx = ptr_q;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && valid_i[j]) begin
        found   = 1'b1;
        win_idx = PW'(j);
      end
    end
    if (found) grant_o[win_idx] = 1'b1;
  end

  assign grant_any_o = found;

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter with pending-write scoreboard
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  rf_wb_arbiter_if.slave       bus
);

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [NUM_REQ-1:0] arb_valid;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;

  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;

  logic               rf_w_q, rf_w_d;
  logic [ADDR_W-1:0]  rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]  rf_data_q, rf_data_d;
  logic [NREGS-1:0]   sb_q, sb_d;

  assign arb_valid = ena ? bus.req_valid : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (arb_valid),
    .advance_i   (ena),
    .grant_o     (grant),
    .grant_any_o (grant_any)
  );

  // Ready is forced low during reset so nothing is handed off into a flushed pipeline.
  assign bus.req_ready = rst ? '0 : grant;

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        win_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rf_w_d    = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (ena && grant_any) begin
      rf_w_d    = (win_addr != ZERO_ADDR);
      rf_addr_d = win_addr;
      rf_data_d = win_data;
    end
  end

  // Clear for the committing write first, so a same-edge issue to that register wins.
  always_comb begin
    sb_d = sb_q;
    if (ena) begin
      if (rf_w_q) sb_d[rf_addr_q] = 1'b0;
      if (bus.issue_valid && (bus.issue_addr != ZERO_ADDR)) sb_d[bus.issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_w_q    <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      sb_q      <= '0;
    end else begin
      rf_w_q    <= rf_w_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      sb_q      <= sb_d;
    end
  end

  assign bus.rs_busy = (bus.rs_addr != ZERO_ADDR) && sb_q[bus.rs_addr];
  assign bus.rt_busy = (bus.rt_addr != ZERO_ADDR) && sb_q[bus.rt_addr];

  assign bus.rf_w    = rf_w_q;
  assign bus.rf_addr = rf_addr_q;
  assign bus.rf_data = rf_data_q;

endmodule
